// File: rtl/cpu_seq_pkg.sv
// cpu_seq shared definitions: FSM state encodings, nop, trap causes.
// Trap support is built only with CPU_SEQ_TRAP_EN defined.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;

endpackage

// File: rtl/cpu_seq_if.sv
// Memory-manager side of the sequencer: fetch and data handshakes.
// master = sequencer, slave = memory manager.
interface cpu_seq_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    output dmem_req,
    input  imem_ack,
    input  imem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  dmem_req,
    output imem_ack,
    output imem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/cpu_seq_pc_unit.sv
// Program counter: sequential/branch advance in WB, redirect on trap.
// Taken targets are word-aligned by dropping bits [1:0].
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            trap,
  input  logic            taken_branch,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt_al;
  logic [XLEN-1:0] next_pc;

  assign tgt_al = target & ~XLEN'(3);

  // select the next pc; pc+4 wraps naturally
  always_comb begin
    next_pc = pc_q;
    if (trap)
      next_pc = TRAP_VECTOR;
    else if (adv)
      next_pc = taken_branch ? tgt_al
                             : pc_q + XLEN'(4);
  end

  // pc register
  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_VECTOR;
    else
      pc_q <= next_pc;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle control sequencer with handshake-stalled fetch/mem.
// Define CPU_SEQ_TRAP_EN to enable illegal/misaligned traps.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 32
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  cpu_seq_if.master        bus,
  output logic [31:0]      instr,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             rd_en,
  input  logic [4:0]       rd,
  input  logic             illegal,
  input  logic             taken_branch,
  input  logic [XLEN-1:0]  target,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  output logic [XLEN-1:0]  mepc,
  output logic [3:0]       mcause
);

  state_t           state_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] retired_q;
  logic             trap_hit;

`ifdef CPU_SEQ_TRAP_EN
  logic [XLEN-1:0] mepc_q;
  logic [3:0]      mcause_q;

  assign trap_hit = illegal
                  | (taken_branch & (|target[1:0]));

  // trap CSRs: cause chosen in EXEC, epc taken in TRAP
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      if (state_q == S_EXEC && trap_hit)
        mcause_q <= illegal ? CAUSE_ILLEGAL
                            : CAUSE_MISALIGN;
      if (state_q == S_TRAP)
        mepc_q <= pc;
    end
  end

  assign mepc   = mepc_q;
  assign mcause = mcause_q;
`else
  logic unused_illegal;

  assign unused_illegal = illegal;
  assign trap_hit       = 1'b0;
  assign mepc           = '0;
  assign mcause         = '0;
`endif

  // sequencer FSM, instruction latch and retire counter
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instr_q   <= NOP_INSTR;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH:
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            state_q <= S_DECODE;
          end
        S_DECODE:
          state_q <= S_EXEC;
        S_EXEC:
          if (trap_hit)
            state_q <= S_TRAP;
          else if (is_load | is_store)
            state_q <= S_MEM;
          else
            state_q <= S_WB;
        S_MEM:
          if (bus.dmem_ack)
            state_q <= S_WB;
        S_WB: begin
          retired_q <= retired_q + CNT_W'(1);
          state_q   <= S_FETCH;
        end
        default:
          state_q <= S_FETCH;
      endcase
    end
  end

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_pc (
    .clk          (CLK100MHZ),
    .rst          (rst),
    .adv          (state_q == S_WB),
    .trap         (state_q == S_TRAP),
    .taken_branch (taken_branch),
    .target       (target),
    .pc           (pc)
  );

  assign bus.imem_req  = (state_q == S_FETCH) & ~rst;
  assign bus.dmem_req  = (state_q == S_MEM) & ~rst;
  assign bus.imem_addr = pc;

  assign rf_we = (state_q == S_WB) & rd_en
               & (|rd) & ~rst;

  assign instr   = instr_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: random instruction stream vs model.
// Honours CPU_SEQ_TRAP_EN when the build defines it.
module tb_cpu_seq;
  import cpu_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef CPU_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_seq_if #(.XLEN(XLEN)) bus ();

  logic [31:0]      instr;
  logic             is_load = 0;
  logic             is_store = 0;
  logic             rd_en = 0;
  logic [4:0]       rd = 0;
  logic             illegal = 0;
  logic             taken_branch = 0;
  logic [31:0]      target = 0;
  logic             rf_we;
  logic [2:0]       state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] retired;
  logic [31:0]      mepc;
  logic [3:0]       mcause;

  cpu_seq #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK100MHZ    (clk),
    .rst          (rst),
    .bus          (bus),
    .instr        (instr),
    .is_load      (is_load),
    .is_store     (is_store),
    .rd_en        (rd_en),
    .rd           (rd),
    .illegal      (illegal),
    .taken_branch (taken_branch),
    .target       (target),
    .rf_we        (rf_we),
    .state        (state),
    .pc           (pc),
    .retired      (retired),
    .mepc         (mepc),
    .mcause       (mcause)
  );

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] ins;
    logic [31:0] pc1;
    logic [31:0] ret;
    logic [31:0] epc;
    logic [3:0]  cause;
    int          cyc;
    int          wen;
    int          dreq;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  logic [31:0] m_pc = RV;
  logic [31:0] m_ret = 0;
  logic [31:0] m_epc = 0;
  logic [3:0]  m_cause = 0;

  bit          mon_en = 0;
  logic [2:0]  prev = 3'd7;
  int          cyc = 0;
  int          wn = 0;
  int          dn = 0;
  logic [31:0] a0 = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  endtask

  task automatic retire_chk();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL sb_underflow: got retire expected none");
      return;
    end
    e = sb.pop_front();
    chk("fetch_addr", 64'(a0), 64'(e.pc0));
    chk("instr", 64'(instr), 64'(e.ins));
    chk("pc", 64'(pc), 64'(e.pc1));
    chk("retired", 64'(retired), 64'(e.ret));
    chk("mepc", 64'(mepc), 64'(e.epc));
    chk("mcause", 64'(mcause), 64'(e.cause));
    chk("cycles", 64'(cyc), 64'(e.cyc));
    chk("rf_we_pulses", 64'(wn), 64'(e.wen));
    chk("dmem_req_cycles", 64'(dn), 64'(e.dreq));
  endtask

  // monitor: per-instruction tallies, compare on return to fetch
  always begin
    @(negedge clk);
    #1;
    if (rst || !mon_en) begin
      cyc = 0;
      wn = 0;
      dn = 0;
      prev = 3'd7;
    end else begin
      if (state == 3'd0 && prev != 3'd0) begin
        if (prev == 3'd4 || prev == 3'd5)
          retire_chk();
        cyc = 0;
        wn = 0;
        dn = 0;
        a0 = bus.imem_addr;
      end
      cyc++;
      wn += int'(rf_we);
      dn += int'(bus.dmem_req);
      prev = state;
    end
  end

  // issue one instruction; model result goes to scoreboard
  task automatic run(input bit ld, input bit st,
                     input bit re, input logic [4:0] r,
                     input bit ill, input bit tk,
                     input logic [31:0] tg,
                     input int iw, input int dw,
                     input logic [31:0] rdat);
    exp_t e;
    bit   trap;
    bit   mem;
    trap = TRAP_EN && (ill || (tk && tg[1:0] != 2'b00));
    mem = ld | st;
    e.pc0 = m_pc;
    e.ins = rdat;
    if (trap) begin
      m_cause = ill ? 4'd2 : 4'd0;
      m_epc = m_pc;
      m_pc = TV;
      e.cyc = iw + 4;
      e.wen = 0;
      e.dreq = 0;
    end else begin
      m_pc = tk ? {tg[31:2], 2'b00} : m_pc + 32'd4;
      m_ret = m_ret + 1;
      e.cyc = iw + 4 + (mem ? dw + 1 : 0);
      e.wen = (re && r != 5'd0) ? 1 : 0;
      e.dreq = mem ? dw + 1 : 0;
    end
    e.pc1 = m_pc;
    e.ret = m_ret;
    e.epc = m_epc;
    e.cause = m_cause;
    sb.push_back(e);

    is_load = ld;
    is_store = st;
    rd_en = re;
    rd = r;
    illegal = ill;
    taken_branch = tk;
    target = tg;
    for (int i = 0; i < iw; i++) begin
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'($urandom);
      bus.imem_rdata = $urandom;
      @(negedge clk);
    end
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.imem_rdata = rdat;
    @(negedge clk);
    repeat (2) begin
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = $urandom;
      bus.dmem_ack = 1'($urandom);
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (state == 3'd3) begin
      for (int i = 0; i < dw; i++) begin
        bus.imem_ack = 1'($urandom);
        bus.imem_rdata = $urandom;
        @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
    end
    for (int i = 0; i < 8 && state != 3'd0; i++)
      @(negedge clk);
    if (state != 3'd0) begin
      checks++;
      errs++;
      $display("FAIL fetch_timeout: got state %0d expected 0",
               state);
      finish_run();
    end
  endtask

  task automatic rand_instr();
    bit          ld;
    bit          st;
    logic [31:0] tg;
    ld = ($urandom % 4) == 0;
    st = !ld && (($urandom % 4) == 0);
    tg = $urandom;
    if (($urandom % 4) != 0)
      tg[1:0] = 2'b00;
    run(ld, st, 1'($urandom), 5'($urandom % 8),
        ($urandom % 8) == 0, ($urandom % 3) == 0, tg,
        int'($urandom % 3), int'($urandom % 4), $urandom);
  endtask

  initial begin
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.dmem_ack = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_instr", 64'(instr), 64'(NOP));
    chk("rst_pc", 64'(pc), 64'(RV));
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_mepc", 64'(mepc), 64'd0);
    chk("rst_mcause", 64'(mcause), 64'd0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("post_rst_imem_req", 64'(bus.imem_req), 64'd1);

    run(0, 0, 1, 5'd1, 0, 0, 32'h0, 0, 0, 32'h0050_0093);
    run(1, 0, 1, 5'd5, 0, 0, 32'h0, 0, 3, 32'h0000_A283);
    run(0, 0, 0, 5'd0, 0, 1, 32'h40, 1, 0, 32'h0000_0063);
    run(0, 0, 1, 5'd1, 0, 1, 32'hFFFF_FFFC, 0, 0,
        32'hFFDF_F0EF);
    run(0, 0, 0, 5'd0, 0, 0, 32'h0, 0, 0, 32'h0000_0063);
    run(0, 0, 1, 5'd0, 0, 0, 32'h0, 2, 0, 32'h0050_0013);
    run(0, 1, 0, 5'd0, 0, 0, 32'h0, 0, 0, 32'h0050_2023);
    run(0, 0, 1, 5'd3, 1, 0, 32'h0, 0, 0, 32'hFFFF_FFFF);
    run(0, 0, 1, 5'd1, 0, 1, 32'h102, 0, 0, 32'h1020_00EF);
    for (int i = 0; i < 60; i++)
      rand_instr();

    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drain_1", 64'(sb.size()), 64'd0);
    is_load = 1'b1;
    is_store = 1'b0;
    rd_en = 1'b1;
    rd = 5'd5;
    illegal = 1'b0;
    taken_branch = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_2283;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("mem_wait_state", 64'(state), 64'd3);
    @(negedge clk);
    chk("mem_wait_dmem_req", 64'(bus.dmem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("mem_rst_dmem_req", 64'(bus.dmem_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    chk("mem_rst_state", 64'(state), 64'd0);
    chk("mem_rst_pc", 64'(pc), 64'(RV));
    chk("mem_rst_retired", 64'(retired), 64'd0);
    chk("mem_rst_instr", 64'(instr), 64'(NOP));
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("late_ack_state", 64'(state), 64'd0);
    m_pc = RV;
    m_ret = 0;
    m_epc = 0;
    m_cause = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++)
      rand_instr();

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain_2", 64'(sb.size()), 64'd0);
    finish_run();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Parametrised multi-cycle control sequencer and PC unit for the RV32 core.
- Replaces the fixed free-running 4-state counter with a handshake-driven FSM. Fetch and load/store stall on memory acknowledge.
- Owns pc, the latched instruction, the register-file write strobe and a retired-instruction counter.
- Sits between decode/alu/branch and the memory manager.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_VECTOR, 32'h0000_0000, pc value after reset.
- TRAP_VECTOR, 32'h0000_0100, pc loaded on trap (used only with CPU_SEQ_TRAP_EN).
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK100MHZ  in  1  system clock; single clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched instruction, feeds decode.
- is_load  in  1  decoded load.
- is_store  in  1  decoded store.
- rd_en  in  1  decoded destination-register write enable.
- rd  in  5  decoded destination register.
- illegal  in  1  decode found no valid opcode.
- taken_branch  in  1  branch/jump taken.
- target  in  XLEN  branch/jump target address.
- dmem_req  out  1  data memory request.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- state  out  3  current FSM state.
- pc  out  XLEN  current program counter.
- retired  out  CNT_W  count of retired instructions.
- mepc  out  XLEN  pc of the trapping instruction (tied 0 without macro).
- mcause  out  4  trap cause (tied 0 without macro).

Behaviour:
- Reset values: state=FETCH, pc=RESET_VECTOR, instr=32'h0000_0013 (nop), retired=0, mepc=0, mcause=0. rf_we, imem_req and dmem_req are 0 in the reset cycle.
- Reset mid-access: outstanding request is abandoned; a late ack after reset is ignored.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Output decoding:
  - imem_req = (state==FETCH)&!rst.
  - dmem_req = (state==MEM)&!rst.
  - imem_addr = pc.
  - rf_we = (state==WB)&rd_en&(rd!=0).
- FETCH:
  - Hold until imem_ack; zero-wait ack in the same cycle is legal.
  - On ack: instr<=imem_rdata, go to DECODE.
- DECODE: one cycle, then EXEC.
- EXEC: one cycle.
  - If is_load|is_store, go to MEM; else go to WB.
  - Trap check per macro (see Optional Feature).
- MEM:
  - Hold until dmem_ack, then go to WB.
  - Wait cycles are unbounded; no timeout.
- WB: one cycle.
  - pc <= taken_branch ? target : pc+4; pc+4 wraps modulo 2^XLEN.
  - retired <= retired+1; counter wraps at 2^CNT_W.
  - Then go to FETCH.
- Latency with zero-wait memory: ALU/branch instruction = 4 cycles; load/store = 5 cycles. Each wait cycle adds 1.
- Ack on imem or dmem outside its request state is ignored.
- Simultaneous imem_ack and rst: reset wins; instr is not updated.
- state=6/7 (unreachable): go to FETCH next cycle.

Optional Feature:
- Macro: CPU_SEQ_TRAP_EN.
- Defined: in EXEC, if illegal=1, or taken_branch=1 with target[1:0]!=0, go to TRAP instead of MEM/WB.
  - Cause codes: illegal → mcause=2; misaligned target → mcause=0. Illegal takes priority.
  - TRAP (one cycle): mepc<=pc, pc<=TRAP_VECTOR, no rf_we, retired unchanged, then go to FETCH.
- Undefined:
  - TRAP state is never entered; illegal is ignored and the instruction executes as decoded.
  - Taken target is loaded with bits [1:0] forced to 0.
  - mepc and mcause are tied to 0.

Decomposition:
- Package cpu_pkg: state encodings (S_FETCH..S_TRAP), NOP_INSTR, cause codes (CAUSE_MISALIGN=0, CAUSE_ILLEGAL=2).
- Sub-module pc_unit: pc register, next-pc select, alignment handling and trap redirect.
- The FSM stays in cpu_seq.

Test Plan:
- Reset, then zero-wait ALU instruction (addi x1,x0,5 = 32'h0050_0093):
  - Expect imem_addr=0 in cycle 0 and rf_we pulse in cycle 3.
  - pc=4 and retired=1 in cycle 4.
- Load with dmem_ack delayed 3 cycles:
  - MEM held 4 cycles, dmem_req high throughout.
  - rf_we one cycle after ack; total 8 cycles.
- Taken branch, target=32'h40 → pc=32'h40 after WB.
- pc=32'hFFFF_FFFC, not taken → pc wraps to 0.
- rd=0 with rd_en=1 → rf_we never asserts; retired still increments.
- TRAP_EN cases:
  - illegal=1 at pc=8 → mepc=8, mcause=2, pc=32'h100, retired unchanged.
  - Without the macro, the same stimulus retires normally with pc=12.
  - Assert rst during a MEM wait → state=FETCH, pc=0 next cycle; a later dmem_ack is ignored.
